// File: rtl/ble_lutk_frac_cfg_pkg.sv
//==============================================================================
// Module : ble_pkg
// Desc   : Config-chain layout constants and decoded mode struct for the BLE.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package ble_pkg;

    localparam int CFG_TT_LSB = 0;

    typedef struct packed {
        logic ce_use;
        logic ff_init;
        logic out1_reg;
        logic out0_reg;
        logic frac;
    } cfg_mode_t;

    function automatic int cfg_bits(input int k);
        return (1 << k) + 5;
    endfunction

    function automatic int cfg_frac_ofs(input int k);
        return (1 << k);
    endfunction

    function automatic int cfg_out0_ofs(input int k);
        return (1 << k) + 1;
    endfunction

    function automatic int cfg_out1_ofs(input int k);
        return (1 << k) + 2;
    endfunction

    function automatic int cfg_init_ofs(input int k);
        return (1 << k) + 3;
    endfunction

    function automatic int cfg_ce_ofs(input int k);
        return (1 << k) + 4;
    endfunction

endpackage : ble_pkg

`default_nettype wire

// File: rtl/ble_lutk_frac_cfg_lut.sv
//==============================================================================
// Module : lut_k_frac
// Desc   : Combinational K-input LUT, optionally split into two (K-1)-LUTs.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module lut_k_frac #(
    parameter int K = 4
) (
    input  logic [(1<<K)-1:0] i_tt,
    input  logic [K-1:0]      i_ble_in,
    input  logic              i_frac,
    output logic              o_lut0,
    output logic              o_lut1
);

    // In fractured mode the MSB input is replaced by a fixed half-table select.
    logic [K-1:0] w_idx_lo;
    logic [K-1:0] w_idx_hi;

    assign w_idx_lo = {1'b0, i_ble_in[K-2:0]};
    assign w_idx_hi = {1'b1, i_ble_in[K-2:0]};

    assign o_lut0 = i_frac ? i_tt[w_idx_lo] : i_tt[i_ble_in];
    assign o_lut1 = i_frac ? i_tt[w_idx_hi] : i_tt[i_ble_in];

endmodule : lut_k_frac

`default_nettype wire

// File: rtl/ble_lutk_frac_cfg.sv
//==============================================================================
// Module : ble_lutk_frac_cfg
// Desc   : Fracturable K-LUT logic element with two FFs and its own config chain.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ble_lutk_frac_cfg
    import ble_pkg::*;
#(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_shift,
    input  logic         ccff_head,
    output logic         ccff_tail,
    output logic         cfg_done,
    input  logic [K-1:0] ble_in,
    input  logic         ble_ce,
    input  logic         ble_sr,
    output logic [1:0]   ble_out
);

    localparam int TT_BITS  = 1 << K;
    localparam int CFG_BITS = cfg_bits(K);
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] r_cfg_q;
    logic [CFG_BITS-1:0] w_cfg_d;
    logic [CNT_W-1:0]    r_cnt_q;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [1:0]          r_ff_q;
    logic [1:0]          w_ff_d;
    cfg_mode_t           w_mode;
    logic                w_lut0;
    logic                w_lut1;
    logic                w_cnt_full;

    assign w_mode.frac     = r_cfg_q[cfg_frac_ofs(K)];
    assign w_mode.out0_reg = r_cfg_q[cfg_out0_ofs(K)];
    assign w_mode.out1_reg = r_cfg_q[cfg_out1_ofs(K)];
    assign w_mode.ff_init  = r_cfg_q[cfg_init_ofs(K)];
    assign w_mode.ce_use   = r_cfg_q[cfg_ce_ofs(K)];

    lut_k_frac #(
        .K (K)
    ) u_lut (
        .i_tt     (r_cfg_q[CFG_TT_LSB +: TT_BITS]),
        .i_ble_in (ble_in),
        .i_frac   (w_mode.frac),
        .o_lut0   (w_lut0),
        .o_lut1   (w_lut1)
    );

    assign w_cnt_full = (r_cnt_q == CNT_FULL);

    // Shifting freezes user state so a reload never disturbs held FF values.
    always_comb begin
        w_cfg_d = r_cfg_q;
        w_cnt_d = r_cnt_q;
        w_ff_d  = r_ff_q;
        if (cfg_shift) begin
            w_cfg_d = {ccff_head, r_cfg_q[CFG_BITS-1:1]};
            if (!w_cnt_full) begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
            end
        end else if (ble_sr) begin
            w_ff_d = {2{w_mode.ff_init}};
        end else if (!w_mode.ce_use || ble_ce) begin
            w_ff_d = {w_lut1, w_lut0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_q <= '0;
            r_cnt_q <= '0;
            r_ff_q  <= '0;
        end else begin
            r_cfg_q <= w_cfg_d;
            r_cnt_q <= w_cnt_d;
            r_ff_q  <= w_ff_d;
        end
    end

    assign ccff_tail = r_cfg_q[0];
    assign cfg_done  = w_cnt_full & ~cfg_shift;

    assign ble_out[0] = cfg_done ? (w_mode.out0_reg ? r_ff_q[0] : w_lut0) : 1'b0;
    assign ble_out[1] = cfg_done ? (w_mode.out1_reg ? r_ff_q[1] : w_lut1) : 1'b0;

endmodule : ble_lutk_frac_cfg

`default_nettype wire

// File: tb/tb_ble_lutk_frac_cfg.sv
//==============================================================================
// Module : tb_ble_lutk_frac_cfg
// Desc   : Scoreboard bench for ble_lutk_frac_cfg (K=4) against a spec-level model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_ble_lutk_frac_cfg;

    localparam int K  = 4;
    localparam int CB = 21;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_shift = 1'b0;
    logic       ccff_head = 1'b0;
    logic       ccff_tail;
    logic       cfg_done;
    logic [3:0] ble_in = 4'h0;
    logic       ble_ce = 1'b0;
    logic       ble_sr = 1'b0;
    logic [1:0] ble_out;

    ble_lutk_frac_cfg #(.K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_shift (cfg_shift),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .cfg_done  (cfg_done),
        .ble_in    (ble_in),
        .ble_ce    (ble_ce),
        .ble_sr    (ble_sr),
        .ble_out   (ble_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [1:0] out;
        logic       tail;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: config word, number of shifts seen, FF pair.
    bit [CB-1:0] m_cfg  = '0;
    int          m_cnt  = 0;
    bit [1:0]    m_ff   = '0;
    bit          m_valid = 1'b0;

    function automatic bit [1:0] model_lut(input bit [CB-1:0] c, input bit [3:0] in);
        int i0, i1;
        if (c[16]) begin
            i0 = int'(in) % 8;
            i1 = 8 + int'(in) % 8;
        end else begin
            i0 = int'(in);
            i1 = int'(in);
        end
        return {c[i1], c[i0]};
    endfunction

    task automatic step(input bit rst, input bit sh, input bit head,
                        input bit [3:0] in, input bit ce, input bit sr);
        exp_t     e;
        bit [1:0] l;
        bit       done;
        bit [CB-1:0] n_cfg;
        int       n_cnt;
        bit [1:0] n_ff;
        reset = rst; cfg_shift = sh; ccff_head = head;
        ble_in = in; ble_ce = ce; ble_sr = sr;
        l    = model_lut(m_cfg, in);
        done = (m_cnt == CB) && !sh;
        if (m_valid) begin
            e.c    = cyc;
            e.tail = m_cfg[0];
            e.done = done;
            e.out[0] = done ? (m_cfg[17] ? m_ff[0] : l[0]) : 1'b0;
            e.out[1] = done ? (m_cfg[18] ? m_ff[1] : l[1]) : 1'b0;
            sb.push_back(e);
        end
        n_cfg = m_cfg; n_cnt = m_cnt; n_ff = m_ff;
        if (rst) begin
            n_cfg = '0; n_cnt = 0; n_ff = '0;
        end else if (sh) begin
            n_cfg = (m_cfg >> 1) | (CB'(head) << (CB - 1));
            n_cnt = (m_cnt < CB) ? m_cnt + 1 : CB;
        end else if (sr) begin
            n_ff = {m_cfg[19], m_cfg[19]};
        end else if (!m_cfg[20] || ce) begin
            n_ff = l;
        end
        @(posedge clk);
        m_cfg = n_cfg; m_cnt = n_cnt; m_ff = n_ff;
        if (rst) m_valid = 1'b1;
        #1;
    endtask

    task automatic idle(input bit [3:0] in, input bit ce, input bit sr);
        step(1'b0, 1'b0, 1'b0, in, ce, sr);
    endtask

    task automatic load(input bit [15:0] tt, input bit [4:0] mode);
        bit [CB-1:0] w;
        w = {mode, tt};
        for (int i = 0; i < CB; i++)
            step(1'b0, 1'b1, w[i], 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    endtask

    // Monitor: compare every expectation registered for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks += 3;
            if (e.c != cyc) begin
                errors++;
                $display("FAIL stale_entry cyc=%0d entry_cyc=%0d", cyc, e.c);
            end
            if (ble_out !== e.out) begin
                errors++;
                $display("FAIL ble_out cyc=%0d got=%b exp=%b", cyc, ble_out, e.out);
            end
            if (ccff_tail !== e.tail) begin
                errors++;
                $display("FAIL ccff_tail cyc=%0d got=%b exp=%b", cyc, ccff_tail, e.tail);
            end
            if (cfg_done !== e.done) begin
                errors++;
                $display("FAIL cfg_done cyc=%0d got=%b exp=%b", cyc, cfg_done, e.done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // mode = {ce_use, ff_init, out1_reg, out0_reg, frac}
    initial begin
        bit [CB-1:0] pat;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1);
        idle(4'hF, 1'b1, 1'b0);

        // AND4, all comb outputs
        load(16'h8000, 5'b00000);
        idle(4'hF, 1'b0, 1'b0);
        idle(4'hE, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) idle(4'($urandom_range(0, 15)), 1'($urandom), 1'b0);

        // fractured xor3 / maj3
        load(16'hE896, 5'b00001);
        idle(4'b0011, 1'b0, 1'b0);
        idle(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) idle(4'($urandom_range(0, 15)), 1'($urandom), 1'b0);

        // registered out0 with clock enable and init=1
        load(16'h8000, 5'b11010);
        idle(4'h0, 1'b0, 1'b1);
        idle(4'h0, 1'b0, 1'b0);
        idle(4'h0, 1'b0, 1'b0);
        idle(4'h0, 1'b1, 1'b0);
        idle(4'h0, 1'b0, 1'b0);
        idle(4'h0, 1'b1, 1'b1);
        idle(4'h0, 1'b0, 1'b0);

        // reload same config with ff0=1: outputs forced low, FF preserved
        load(16'h8000, 5'b11010);
        idle(4'h0, 1'b0, 1'b0);
        idle(4'h3, 1'b0, 1'b0);

        // 42-bit pass-through of a random pattern
        pat = CB'($urandom);
        for (int i = 0; i < 2 * CB; i++)
            step(1'b0, 1'b1, (i < CB) ? pat[i] : 1'($urandom), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        idle(4'h7, 1'b0, 1'b0);
        idle(4'h8, 1'b1, 1'b0);

        // reset in the middle of a load, then reload
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
        idle(4'hF, 1'b1, 1'b0);
        load(16'h8000, 5'b00000);
        idle(4'hF, 1'b0, 1'b0);

        // random configs and traffic
        for (int r = 0; r < 8; r++) begin
            load(16'($urandom), 5'($urandom));
            for (int i = 0; i < 25; i++) begin
                int p;
                p = $urandom_range(0, 49);
                step(p == 0, p < 3, 1'($urandom), 4'($urandom_range(0, 15)),
                     1'($urandom), ($urandom_range(0, 5) == 0));
            end
        end

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ble_lutk_frac_cfg

`default_nettype wire
